ad_wave_capture: RTL

Receive-side counterpart of the DA waveform sender: drives the ADC sample clock, registers the 8-bit ADC output once per conversion, and waits for an optional level trigger. On a trigger it captures a fixed-length record into an internal sample buffer, which downstream logic reads back through a synchronous read port. It sits beside the DA path in the AD/DA top level and is clocked from the PLL's 100 MHz output.

---
 rtl/ad_wave_capture.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ad_wave_capture.sv
// ADC capture front end: divides clk into the ADC conversion clock, registers one
// sample per conversion and stores a fixed-length record after an optional level trigger.
module ad_wave_capture #(
  parameter int CLK_DIV = 4,
  parameter int DEPTH   = 256,
  parameter int AW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    ad_data,
  input  logic          ad_otr,
  output logic          ad_clk,
  input  logic          arm,
  input  logic          trig_en,
  input  logic [7:0]    trig_level,
  output logic          busy,
  output logic          done,
  output logic          otr_seen,
  output logic [AW:0]   fill,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [1:0]    state_dbg
);

  // Handshake: arm is a single-cycle pulse with no ready; it is always accepted
  // and takes priority over a sample strobe arriving on the same edge.

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HALF     = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] HALF_M1  = DW'(CLK_DIV / 2 - 1);
  localparam logic [AW:0]   FILL_LAST = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] div_cnt, div_nxt;
  logic          ad_clk_q;
  logic [7:0]    samp;
  logic          samp_otr;
  logic          stb;
  logic [7:0]    prev;
  logic          prev_valid;
  logic [AW-1:0] wr_ptr;
  logic          otr_q;
  logic [7:0]    mem [DEPTH];

  logic clr, wr_en, load_prev, trig_hit, last_wr;

  // Divider: ad_clk is registered from the next count so it never glitches.
  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      ad_clk_q <= 1'b0;
    end else begin
      div_cnt  <= div_nxt;
      ad_clk_q <= (div_nxt >= HALF);
    end
  end

  assign ad_clk = ad_clk_q;

  // Sample on the edge where ad_clk rises; stb marks samp valid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp     <= '0;
      samp_otr <= 1'b0;
      stb      <= 1'b0;
    end else begin
      stb <= (div_cnt == HALF_M1);
      if (div_cnt == HALF_M1) begin
        samp     <= ad_data;
        samp_otr <= ad_otr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    trig_hit = prev_valid && (prev < trig_level) && (samp >= trig_level);
    last_wr  = (fill == FILL_LAST);
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    wr_en     = 1'b0;
    load_prev = 1'b0;
    if (arm) begin
      clr       = 1'b1;
      state_nxt = trig_en ? S_WAIT : S_CAPTURE;
    end else begin
      case (state)
        S_WAIT: begin
          if (stb) begin
            load_prev = 1'b1;
            if (trig_hit) begin
              wr_en     = 1'b1;
              state_nxt = last_wr ? S_DONE : S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (stb) begin
            wr_en = 1'b1;
            if (last_wr) state_nxt = S_DONE;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      fill       <= '0;
      otr_q      <= 1'b0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= '0;
      fill       <= '0;
      otr_q      <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        fill   <= fill + 1'b1;
        otr_q  <= otr_q | samp_otr;
      end
      if (load_prev) begin
        prev       <= samp;
        prev_valid <= 1'b1;
      end
    end
  end

  // Buffer has no reset; the read register does, so rd_data starts at 0.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= samp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

  assign busy      = (state == S_WAIT) || (state == S_CAPTURE);
  assign done      = (state == S_DONE);
  assign otr_seen  = otr_q;
  assign state_dbg = state;

endmodule
